fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Takes the current PC and issues in-order requests to instruction memory, which may have variable latency.
- Buffers returned instructions with their PCs in a small in-order queue and presents them to decode over a valid/ready handshake.
- Drives the PC's stall input; on a branch it flushes the queue and discards wrong-path responses still in flight.

Parameters:
- DATAW, 32, width of PC, addresses and instruction words.
- DEPTH, 4, fetch buffer entries (power of two, ≥2); bounds requests in flight plus instructions buffered.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_in  input  DATAW  current PC from the program counter.
- branch  input  1  same signal the PC sees; the PC loads the branch target this cycle.
- halt  input  1  stop issuing fetches.
- stall_out  output  1  to PC stall; high = PC must hold.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  DATAW  fetch address (= pc_in).
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_resp_valid  input  1  response valid; responses return in request order, one per request.
- imem_resp_data  input  DATAW  instruction word.
- dec_valid  output  1  instruction available to decode.
- dec_instr  output  DATAW  instruction at queue head.
- dec_pc  output  DATAW  PC of dec_instr.
- dec_ready  input  1  decode consumes the head when dec_valid & dec_ready.

Behaviour:
- Entries: circular buffer of DEPTH slots {pc, instr, filled}, with three pointers.
  - alloc_ptr: advances on request fire.
  - fill_ptr: advances on kept response.
  - head_ptr: advances on pop.
  - Pointers are log2(DEPTH)+1 bits; the MSB distinguishes full from empty.
- occupancy = alloc_ptr − head_ptr; unfilled = alloc_ptr − fill_ptr.
- Request issue:
  - imem_req_valid = ~rst & ~halt & ~branch & (occupancy < DEPTH).
  - fire = imem_req_valid & imem_req_ready.
  - On fire, slot[alloc] gets pc = pc_in and filled = 0.
- stall_out = ~fire, so the PC advances by 4 exactly when a fetch is accepted.
  - When halt is high, stall_out may be 1; the PC holds regardless.
- Response, drop_cnt > 0: the response is discarded and drop_cnt decrements.
- Response, drop_cnt = 0: instr is written to slot[fill], filled = 1, fill_ptr advances.
- Response with unfilled = 0 and drop_cnt = 0 is a protocol violation. It is ignored and flagged by assertion.
- dec_valid = (occupancy > 0) & slot[head].filled. dec_instr and dec_pc come from slot[head], driven from registers.
- Latency:
  - Request fire in cycle N; response no earlier than N+1.
  - dec_valid is high in the cycle after the response is captured; this is a registered fill, with no combinational response-to-decode path.
- Simultaneous fire, fill and pop in one cycle are all legal and all take effect. Full at the start of a cycle means no fire, even if a pop occurs that cycle.
- Branch cycle:
  - No request issues.
  - head_ptr and fill_ptr jump to alloc_ptr, so the buffer empties; filled bits are cleared.
  - drop_cnt_next = drop_cnt + unfilled − (imem_resp_valid ? 1 : 0). A response arriving in the branch cycle is discarded whatever drop_cnt is.
  - A decode pop in the branch cycle is ignored; dec_valid is 0 from the next cycle.
  - First correct-path request issues in cycle N+1 (PC now holds the target).
- Back-to-back branches accumulate drop_cnt correctly. drop_cnt width is log2(DEPTH)+2, and drop_cnt ≤ 2·DEPTH is asserted.
- Reset:
  - All pointers and drop_cnt go to 0; filled bits are cleared.
  - imem_req_valid = 0, dec_valid = 0, stall_out = 1.
  - Reset mid-operation abandons in-flight requests. The memory is reset by the same rst.
- Pointer wrap: modulo 2·DEPTH; slot index = pointer[log2(DEPTH)−1:0].

Decomposition:
- Shared package fetch_pkg holds:
  - localparam DATAW = 32.
  - typedef fetch_entry_t {logic [DATAW-1:0] pc; logic [DATAW-1:0] instr; logic filled;}.
  - A function for pointer-difference occupancy.
- Sub-module fetch_buffer: entry storage plus the alloc/fill/head pointers and flush. The top handles request/drop_cnt/stall logic.

Test Plan:
- Zero-wait memory (ready=1, response 1 cycle later), dec_ready=1, PC from 0 → dec_pc sequence 0, 4, 8, 12…; stall_out=0 every cycle; dec_instr matches memory contents.
- dec_ready=0 with DEPTH=4 → exactly 4 requests fire (addresses 0–12); stall_out=1 from the 5th cycle; PC holds at 16.
  - Release dec_ready → pops 0, 4, 8, 12, then fetch of 16 resumes.
- Memory latency 3, branch asserted with 2 requests unfilled and a response arriving in the branch cycle → drop_cnt=1; that response and the next one are discarded.
  - The first dec_pc after the branch is the target (e.g., 0x100); no wrong-path instruction appears on the decode port.
- imem_req_ready=0 for 5 cycles → stall_out=1 and PC constant for those 5 cycles; no duplicate or skipped addresses afterwards.
- halt=1 mid-stream → no new requests; in-flight responses still delivered to decode. Deassert → fetch continues from the held PC.
- rst asserted with 3 entries occupied and 1 in flight → next cycle dec_valid=0, imem_req_valid=0, stall_out=1; after release, fetch restarts from the PC's reset value 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   DATAW         : width of PC, addresses and instruction words
//   fetch_entry_t : one fetch buffer slot {pc, instr, filled}
//   ptr_diff      : modular difference of two wrap-bit pointers
package fetch_pkg;

    localparam int unsigned DATAW = 32;

    typedef struct packed {
        logic [DATAW-1:0] pc;
        logic [DATAW-1:0] instr;
        logic             filled;
    } fetch_entry_t;

    // Pointers carry one extra wrap bit, so the difference is taken modulo 2^pw.
    function automatic int unsigned ptr_diff(input int unsigned a, input int unsigned b,
                                             input int unsigned pw);
        return (a - b) & ((32'd1 << pw) - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: DEPTH slots with alloc/fill/head pointers.
//   clk, rst        : clock, synchronous active-high reset
//   alloc, alloc_pc : reserve the next slot for a request to alloc_pc
//   fill, fill_instr: write the oldest outstanding slot with its instruction
//   pop             : retire the head slot
//   flush           : drop everything; head and fill jump to alloc
//   occupancy       : allocated slots not yet popped
//   unfilled        : allocated slots still waiting for memory
//   head_valid/pc/instr : head slot presented to decode
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc,
    input  logic [DATAW-1:0]       alloc_pc,
    input  logic                   fill,
    input  logic [DATAW-1:0]       fill_instr,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [$clog2(DEPTH):0] unfilled,
    output logic                   head_valid,
    output logic [DATAW-1:0]       head_pc,
    output logic [DATAW-1:0]       head_instr
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    logic [PW-1:0] alloc_q, fill_q, head_q;
    fetch_entry_t  slots_q [DEPTH];

    logic [IW-1:0] alloc_idx, fill_idx, head_idx;
    assign alloc_idx = alloc_q[IW-1:0];
    assign fill_idx  = fill_q[IW-1:0];
    assign head_idx  = head_q[IW-1:0];

    // alloc targets a free slot and fill an outstanding one, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_q <= '0;
            fill_q  <= '0;
            head_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) slots_q[i].filled <= 1'b0;
        end else if (flush) begin
            head_q <= alloc_q;
            fill_q <= alloc_q;
            for (int i = 0; i < int'(DEPTH); i++) slots_q[i].filled <= 1'b0;
        end else begin
            if (alloc) begin
                slots_q[alloc_idx].pc     <= alloc_pc;
                slots_q[alloc_idx].filled <= 1'b0;
                alloc_q                   <= alloc_q + PW'(1);
            end
            if (fill) begin
                slots_q[fill_idx].instr  <= fill_instr;
                slots_q[fill_idx].filled <= 1'b1;
                fill_q                   <= fill_q + PW'(1);
            end
            if (pop) head_q <= head_q + PW'(1);
        end
    end

    assign occupancy  = PW'(ptr_diff(32'(alloc_q), 32'(head_q), PW));
    assign unfilled   = PW'(ptr_diff(32'(alloc_q), 32'(fill_q), PW));
    assign head_valid = (occupancy != '0) && slots_q[head_idx].filled;
    assign head_pc    = slots_q[head_idx].pc;
    assign head_instr = slots_q[head_idx].instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage between the program counter and decode.
//   clk, rst                    : clock, synchronous active-high reset
//   pc_in, branch, halt         : current PC, redirect this cycle, stop fetching
//   stall_out                   : PC must hold (high unless a fetch is accepted)
//   imem_req_valid/addr/ready   : in-order request channel to instruction memory
//   imem_resp_valid/data        : in-order responses, one per request
//   dec_valid/instr/pc/ready    : head of the fetch buffer to decode
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DATAW-1:0] pc_in,
    input  logic             branch,
    input  logic             halt,
    output logic             stall_out,
    output logic             imem_req_valid,
    output logic [DATAW-1:0] imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_resp_valid,
    input  logic [DATAW-1:0] imem_resp_data,
    output logic             dec_valid,
    output logic [DATAW-1:0] dec_instr,
    output logic [DATAW-1:0] dec_pc,
    input  logic             dec_ready
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;
    localparam int unsigned DW = PW + 1;

    logic [PW-1:0] occupancy, unfilled;
    logic          full, fire, fill, pop;
    logic [DW-1:0] drop_cnt_q, drop_cnt_d, drop_sum;

    assign full           = (occupancy == PW'(DEPTH));
    assign imem_req_valid = ~rst & ~halt & ~branch & ~full;
    assign imem_req_addr  = pc_in;
    assign fire           = imem_req_valid & imem_req_ready;
    assign stall_out      = ~fire;

    // Responses owed to squashed requests are swallowed before any are kept.
    assign fill = imem_resp_valid & ~branch & (drop_cnt_q == '0) & (unfilled != '0);
    assign pop  = dec_valid & dec_ready & ~branch;

    // On a branch every outstanding request becomes wrong-path; a response
    // arriving in that same cycle already pays off one of them.
    always_comb begin
        drop_sum   = drop_cnt_q + DW'(unfilled);
        drop_cnt_d = drop_cnt_q;
        if (branch) begin
            drop_cnt_d = (imem_resp_valid && drop_sum != '0) ? drop_sum - DW'(1) : drop_sum;
        end else if (imem_resp_valid && drop_cnt_q != '0) begin
            drop_cnt_d = drop_cnt_q - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    fetch_buffer #(
        .DEPTH(DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .alloc     (fire),
        .alloc_pc  (pc_in),
        .fill      (fill),
        .fill_instr(imem_resp_data),
        .pop       (pop),
        .flush     (branch),
        .occupancy (occupancy),
        .unfilled  (unfilled),
        .head_valid(dec_valid),
        .head_pc   (dec_pc),
        .head_instr(dec_instr)
    );

    // A response with nothing outstanding is ignored by the logic above.
    resp_has_owner: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (drop_cnt_q != '0 || unfilled != '0));

    drop_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        drop_cnt_q <= DW'(2 * DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays the program counter and a
// variable-latency in-order instruction memory, logs decode pops and fired
// requests, and compares them against hand-computed sequences.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        branch;
    logic        halt;
    logic        stall_out;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;

    fetch_unit #(
        .DEPTH(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .branch         (branch),
        .halt           (halt),
        .stall_out      (stall_out),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } mresp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } pop_t;

    mresp_t      mq[$];
    pop_t        pops[$];
    logic [31:0] fired[$];
    int          cyc;
    int          lat;
    logic [31:0] target;
    int          n_checks;
    int          n_pass;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic check_pop(input string tag, input int idx, input logic [31:0] exp_pc);
        if (idx < pops.size()) begin
            check_eq({tag, "_pc"}, pops[idx].pc, exp_pc);
            check_eq({tag, "_instr"}, pops[idx].instr, mem_word(exp_pc));
        end else begin
            check_eq({tag, "_missing"}, 32'(pops.size()), 32'(idx + 1));
        end
    endtask

    task automatic check_fire(input string tag, input int idx, input logic [31:0] exp_addr);
        if (idx < fired.size()) check_eq(tag, fired[idx], exp_addr);
        else                    check_eq({tag, "_missing"}, 32'(fired.size()), 32'(idx + 1));
    endtask

    // One clock: log what fires this edge, then advance the PC and memory models.
    task automatic step();
        logic f, s, p, r, b;
        #1;
        f = imem_req_valid & imem_req_ready;
        s = stall_out;
        p = dec_valid & dec_ready & ~branch & ~rst;
        r = rst;
        b = branch;
        if (f) begin
            fired.push_back(imem_req_addr);
            mq.push_back('{data: mem_word(imem_req_addr), due: cyc + lat});
        end
        if (p) pops.push_back('{pc: dec_pc, instr: dec_instr});
        @(posedge clk);
        #1;
        cyc++;
        if (r)       begin pc_in = 32'h0; mq.delete(); end
        else if (b)  pc_in = target;
        else if (!s) pc_in = pc_in + 32'd4;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if (!r && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mq[0].data;
            void'(mq.pop_front());
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        branch         = 1'b0;
        halt           = 1'b0;
        dec_ready      = 1'b1;
        imem_req_ready = 1'b1;
        lat            = 1;
        step();
        step();
        #1;
        check_eq("rst_stall", 32'(stall_out), 32'd1);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_dec_valid", 32'(dec_valid), 32'd0);
        rst = 1'b0;
        fired.delete();
        pops.delete();
        cyc = 0;
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        cyc             = 0;
        lat             = 1;
        target          = 32'h100;
        pc_in           = 32'h0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;

        // Zero-wait memory, decode always ready: continuous stream.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            #1;
            check_eq("t1_stall", 32'(stall_out), 32'd0);
            step();
        end
        for (int k = 0; k < 6; k++) check_pop("t1_pop", k, 32'(4 * k));

        // Decode blocked: buffer fills after four requests, then drains in order.
        do_reset();
        dec_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        #1;
        check_eq("t2_fired_cnt", 32'(fired.size()), 32'd4);
        for (int k = 0; k < 4; k++) check_fire("t2_fire", k, 32'(4 * k));
        check_eq("t2_stall", 32'(stall_out), 32'd1);
        check_eq("t2_pc_hold", pc_in, 32'd16);
        check_eq("t2_dec_valid", 32'(dec_valid), 32'd1);
        check_eq("t2_dec_pc", dec_pc, 32'd0);
        dec_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        for (int k = 0; k < 5; k++) check_pop("t2_pop", k, 32'(4 * k));
        check_fire("t2_resume", 4, 32'd16);

        // Latency 3, branch with two outstanding and one response landing that cycle.
        do_reset();
        lat    = 3;
        target = 32'h100;
        for (int i = 0; i < 5; i++) step();
        branch = 1'b1;
        #1;
        check_eq("t3_branch_noreq", 32'(imem_req_valid), 32'd0);
        step();
        branch = 1'b0;
        #1;
        check_eq("t3_flush_dec_valid", 32'(dec_valid), 32'd0);
        check_eq("t3_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
        for (int i = 0; i < 10; i++) step();
        check_pop("t3_pre", 0, 32'h0);
        check_pop("t3_target", 1, 32'h100);
        check_pop("t3_next", 2, 32'h104);
        check_fire("t3_fire_target", 4, 32'h100);

        // Memory not ready for five cycles: PC holds, no skips or duplicates.
        do_reset();
        for (int i = 0; i < 4; i++) step();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("t4_stall", 32'(stall_out), 32'd1);
            check_eq("t4_pc_hold", pc_in, 32'd16);
            step();
        end
        imem_req_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        for (int k = 0; k < 8; k++) check_fire("t4_fire", k, 32'(4 * k));
        for (int k = 0; k < 6; k++) check_pop("t4_pop", k, 32'(4 * k));

        // Halt mid-stream: in-flight responses still reach decode.
        do_reset();
        lat = 3;
        for (int i = 0; i < 3; i++) step();
        halt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq("t5_no_req", 32'(imem_req_valid), 32'd0);
            check_eq("t5_pc_hold", pc_in, 32'd12);
            step();
        end
        halt = 1'b0;
        #1;
        check_eq("t5_drained", 32'(pops.size()), 32'd3);
        for (int i = 0; i < 10; i++) step();
        check_fire("t5_resume", 3, 32'd12);
        check_pop("t5_pop12", 3, 32'd12);
        check_pop("t5_pop16", 4, 32'd16);

        // Reset with three entries filled and one response in flight.
        do_reset();
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        #1;
        check_eq("t6_dec_valid", 32'(dec_valid), 32'd0);
        check_eq("t6_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("t6_stall", 32'(stall_out), 32'd1);
        rst = 1'b0;
        fired.delete();
        pops.delete();
        cyc       = 0;
        dec_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check_fire("t6_restart", 0, 32'h0);
        check_pop("t6_pop0", 0, 32'h0);
        check_pop("t6_pop1", 1, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
